cyq_vm_ctrl: RTL and testbench

Vending-machine controller that sequences a single coin path, two product dispense channels and a change-return mechanism. It accepts half-yuan and one-yuan coin strobes, accumulates credit, and arbitrates the shared dispense resource between product A and product B selections. It then returns change one half-yuan unit per cycle. It sits between the coin/selection front panel and the dispense/change actuators, and supersedes the single-product vending FSM as the top-level sequencer.

---
 rtl/cyq_vm_if.sv | 25 ++
 rtl/cyq_vm_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_cyq_vm_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cyq_vm_if.sv
// Front-panel / actuator bundle of the vending controller.
// The master side is the panel, and the slave side is cyq_vm_ctrl.
interface cyq_vm_if;
    logic [1:0] coin;
    logic [1:0] sel;
    logic       refill;
    logic       dispense_a;
    logic       dispense_b;
    logic       change;
    logic       reject;
    logic       busy;
    logic [3:0] credit;
    logic       empty_a;
    logic       empty_b;

    modport master (
        output coin, sel, refill,
        input  dispense_a, dispense_b, change, reject, busy, credit, empty_a, empty_b
    );

    modport slave (
        input  coin, sel, refill,
        output dispense_a, dispense_b, change, reject, busy, credit, empty_a, empty_b
    );
endinterface

// File: rtl/cyq_vm_ctrl.sv
// Vending controller: it accumulates coin credit, arbitrates A/B dispense and returns change one unit per cycle.
// Defining CYQ_VM_TIMEOUT_EN adds an idle-credit timeout that refunds the credit after TIMEOUT_CYC quiet cycles.
module cyq_vm_ctrl #(
    parameter int unsigned PRICE_A     = 3,
    parameter int unsigned PRICE_B     = 4,
    parameter int unsigned STOCK_INIT  = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    cyq_vm_if.slave vm
);
    localparam logic [3:0] PRICE_A_C = 4'(PRICE_A);
    localparam logic [3:0] PRICE_B_C = 4'(PRICE_B);
    localparam logic [3:0] STOCK_C   = 4'(STOCK_INIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_e;

    function automatic logic [4:0] coin_value(input logic [1:0] coin);
        case (coin)
            2'b01:   coin_value = 5'd1;
            2'b10:   coin_value = 5'd2;
            default: coin_value = 5'd0;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic [3:0] stock_a_q, stock_a_d;
    logic [3:0] stock_b_q, stock_b_d;
    logic       vend_b_q, vend_b_d;
    logic [1:0] coin_prev_q;
    logic       dispense_a_q, dispense_a_d;
    logic       dispense_b_q, dispense_b_d;
    logic       change_q, change_d;
    logic       reject_q, reject_d;
    logic       busy_q, busy_d;
    logic       empty_a_q, empty_a_d;
    logic       empty_b_q, empty_b_d;

    logic       coin_ev_s;
    logic       cancel_s;
    logic [4:0] sum_s;
    logic       sel_a_ok_s;
    logic       sel_b_ok_s;
    logic [3:0] vend_rem_s;
    logic       tmo_hit_s;

    // A held coin level counts once: only the 00 -> non-00 transition is an event.
    assign coin_ev_s  = (vm.coin != 2'b00) && (coin_prev_q == 2'b00);
    assign cancel_s   = coin_ev_s && (vm.coin == 2'b11);
    assign sum_s      = {1'b0, credit_q} + coin_value(vm.coin);
    assign sel_a_ok_s = (vm.sel == 2'b01) && (credit_q >= PRICE_A_C) && (stock_a_q != 4'd0);
    assign sel_b_ok_s = (vm.sel == 2'b10) && (credit_q >= PRICE_B_C) && (stock_b_q != 4'd0);
    assign vend_rem_s = credit_q - (vend_b_q ? PRICE_B_C : PRICE_A_C);

`ifdef CYQ_VM_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             activity_s;

    assign activity_s = coin_ev_s || (vm.sel == 2'b01) || (vm.sel == 2'b10);
    assign tmo_hit_s  = (state_q == S_CREDIT) && !activity_s && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Quiet-cycle counter, which runs only while credit is waiting for a selection
    always_comb begin
        tmo_d = {TMO_W{1'b0}};
        if ((state_q == S_CREDIT) && !activity_s) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = {TMO_W{1'b0}};
        end
    end

    // Timeout counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= {TMO_W{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_s;

    assign tmo_hit_s    = 1'b0;
    assign unused_tmo_s = ^TIMEOUT_CYC;
`endif

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            credit_q     <= 4'd0;
            stock_a_q    <= STOCK_C;
            stock_b_q    <= STOCK_C;
            vend_b_q     <= 1'b0;
            coin_prev_q  <= 2'b00;
            dispense_a_q <= 1'b0;
            dispense_b_q <= 1'b0;
            change_q     <= 1'b0;
            reject_q     <= 1'b0;
            busy_q       <= 1'b0;
            empty_a_q    <= (STOCK_C == 4'd0);
            empty_b_q    <= (STOCK_C == 4'd0);
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            stock_a_q    <= stock_a_d;
            stock_b_q    <= stock_b_d;
            vend_b_q     <= vend_b_d;
            coin_prev_q  <= vm.coin;
            dispense_a_q <= dispense_a_d;
            dispense_b_q <= dispense_b_d;
            change_q     <= change_d;
            reject_q     <= reject_d;
            busy_q       <= busy_d;
            empty_a_q    <= empty_a_d;
            empty_b_q    <= empty_b_d;
        end
    end

    // Next-state, credit and stock update
    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        stock_a_d = stock_a_q;
        stock_b_d = stock_b_q;
        vend_b_d  = vend_b_q;
        case (state_q)
            S_IDLE: begin
                if (vm.refill) begin
                    stock_a_d = STOCK_C;
                    stock_b_d = STOCK_C;
                end else begin
                    stock_a_d = stock_a_q;
                    stock_b_d = stock_b_q;
                end
                if (coin_ev_s && !cancel_s) begin
                    credit_d = sum_s[3:0];
                    state_d  = S_CREDIT;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CREDIT: begin
                if (cancel_s) begin
                    state_d = S_CHANGE;
                end else if (coin_ev_s) begin
                    // An over-range coin is refused, and the credit stays unchanged.
                    if (sum_s <= 5'd15) begin
                        credit_d = sum_s[3:0];
                    end else begin
                        credit_d = credit_q;
                    end
                end else if (sel_a_ok_s) begin
                    state_d  = S_VEND;
                    vend_b_d = 1'b0;
                end else if (sel_b_ok_s) begin
                    state_d  = S_VEND;
                    vend_b_d = 1'b1;
                end else if (tmo_hit_s) begin
                    state_d = S_CHANGE;
                end else begin
                    state_d = S_CREDIT;
                end
            end
            S_VEND: begin
                credit_d = vend_rem_s;
                if (vend_b_q) begin
                    stock_b_d = stock_b_q - 4'd1;
                end else begin
                    stock_a_d = stock_a_q - 4'd1;
                end
                if (vend_rem_s != 4'd0) begin
                    state_d = S_CHANGE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                credit_d = credit_q - 4'd1;
                if (credit_q == 4'd1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CHANGE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = 4'd0;
            end
        endcase
    end

    // Output decode, computed from the upcoming state so that every pulse leaves a flop
    always_comb begin
        dispense_a_d = (state_d == S_VEND) && !vend_b_d;
        dispense_b_d = (state_d == S_VEND) && vend_b_d;
        change_d     = (state_d == S_CHANGE);
        busy_d       = (state_d == S_VEND) || (state_d == S_CHANGE);
        empty_a_d    = (stock_a_d == 4'd0);
        empty_b_d    = (stock_b_d == 4'd0);
        reject_d     = coin_ev_s &&
                       ((state_q == S_VEND) || (state_q == S_CHANGE) ||
                        ((state_q == S_CREDIT) && !cancel_s && (sum_s > 5'd15)));
    end

    assign vm.dispense_a = dispense_a_q;
    assign vm.dispense_b = dispense_b_q;
    assign vm.change     = change_q;
    assign vm.reject     = reject_q;
    assign vm.busy       = busy_q;
    assign vm.credit     = credit_q;
    assign vm.empty_a    = empty_a_q;
    assign vm.empty_b    = empty_b_q;
endmodule

// File: tb/tb_cyq_vm_ctrl.sv
// Bench for cyq_vm_ctrl: a queue-based transaction model predicts every busy cycle.
// It runs directed scenarios and then random coin/selection traffic.
module tb_cyq_vm_ctrl;
    localparam int PA = 3;
    localparam int PB = 4;
    localparam int SI = 8;
`ifdef CYQ_VM_TIMEOUT_EN
    localparam int TO = 64;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cyq_vm_if vm ();

    cyq_vm_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .vm     (vm)
    );

    always #5 clk = ~clk;

    // One entry per future busy cycle: what the outputs show during that cycle.
    typedef struct {
        bit da;
        bit db;
        bit ch;
        int cr;
        bit dec_a;
        bit dec_b;
    } slot_t;

    slot_t      sched[$];
    int         m_credit;
    int         m_stock_a;
    int         m_stock_b;
    int         m_idle;
    logic [1:0] m_prev;

    bit e_da, e_db, e_ch, e_rej, e_busy, e_ea, e_eb;
    int e_cr;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_outputs();
        if (sched.size() != 0) begin
            e_da   = sched[0].da;
            e_db   = sched[0].db;
            e_ch   = sched[0].ch;
            e_cr   = sched[0].cr;
            e_busy = 1'b1;
        end else begin
            e_da   = 1'b0;
            e_db   = 1'b0;
            e_ch   = 1'b0;
            e_cr   = m_credit;
            e_busy = 1'b0;
        end
        e_ea = (m_stock_a == 0);
        e_eb = (m_stock_b == 0);
    endtask

    task automatic model_reset();
        sched.delete();
        m_credit  = 0;
        m_stock_a = SI;
        m_stock_b = SI;
        m_idle    = 0;
        m_prev    = 2'b00;
        e_rej     = 1'b0;
        model_outputs();
    endtask

    task automatic push_change();
        for (int k = m_credit; k > 0; k--) sched.push_back('{1'b0, 1'b0, 1'b1, k, 1'b0, 1'b0});
        m_credit = 0;
    endtask

    task automatic push_vend(input bit b);
        int c;
        int r;
        c = m_credit;
        r = c - (b ? PB : PA);
        sched.push_back('{!b, b, 1'b0, c, !b, b});
        for (int k = r; k > 0; k--) sched.push_back('{1'b0, 1'b0, 1'b1, k, 1'b0, 1'b0});
        m_credit = 0;
    endtask

    task automatic model_step();
        bit    ev;
        int    val;
        slot_t cur;
        ev     = (vm.coin != 2'b00) && (m_prev == 2'b00);
        val    = (vm.coin == 2'b01) ? 1 : (vm.coin == 2'b10) ? 2 : 0;
        m_prev = vm.coin;
        e_rej  = 1'b0;
        if (sched.size() != 0) begin
            cur = sched.pop_front();
            if (cur.dec_a) m_stock_a--;
            if (cur.dec_b) m_stock_b--;
            e_rej = ev;
        end else if (m_credit == 0) begin
            if (vm.refill) begin
                m_stock_a = SI;
                m_stock_b = SI;
            end
            if (ev) m_credit += val;
        end else begin
            if (ev && vm.coin == 2'b11) push_change();
            else if (ev) begin
                if (m_credit + val > 15) e_rej = 1'b1;
                else m_credit += val;
            end
            else if (vm.sel == 2'b01 && m_credit >= PA && m_stock_a > 0) push_vend(1'b0);
            else if (vm.sel == 2'b10 && m_credit >= PB && m_stock_b > 0) push_vend(1'b1);
`ifdef CYQ_VM_TIMEOUT_EN
            else if (vm.sel == 2'b00 || vm.sel == 2'b11) begin
                m_idle++;
                if (m_idle == TO) push_change();
            end
`endif
        end
        if (sched.size() != 0 || m_credit == 0 || ev || vm.sel == 2'b01 || vm.sel == 2'b10) m_idle = 0;
        model_outputs();
    endtask

    always @(posedge clk) begin
        if (rst_n) model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("dispense_a", vm.dispense_a, e_da);
            check("dispense_b", vm.dispense_b, e_db);
            check("change", vm.change, e_ch);
            check("reject", vm.reject, e_rej);
            check("busy", vm.busy, e_busy);
            check("credit", vm.credit, e_cr);
            check("empty_a", vm.empty_a, e_ea);
            check("empty_b", vm.empty_b, e_eb);
        end
    end

    task automatic cyc(input logic [1:0] c, input logic [1:0] s, input logic r);
        vm.coin   = c;
        vm.sel    = s;
        vm.refill = r;
        @(negedge clk);
    endtask

    task automatic coin_in(input logic [1:0] c);
        cyc(c, 2'b00, 1'b0);
        cyc(2'b00, 2'b00, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        logic [1:0] rc;
        logic [1:0] rs;
        int         rr;
        vm.coin   = 2'b00;
        vm.sel    = 2'b00;
        vm.refill = 1'b0;
        model_reset();
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_credit", vm.credit, 0);
        check("rst_busy", vm.busy, 0);
        check("rst_empty_a", vm.empty_a, 0);
        rst_n = 1'b1;

        // Credit 3, buy A: a single dispense and no change
        coin_in(2'b01);
        cyc(2'b10, 2'b00, 1'b0);
        check("credit_3", vm.credit, 3);
        cyc(2'b00, 2'b01, 1'b0);
        check("disp_a_pulse", vm.dispense_a, 1);
        cyc(2'b00, 2'b00, 1'b0);
        check("after_a_credit", vm.credit, 0);
        check("after_a_busy", vm.busy, 0);
        check("after_a_change", vm.change, 0);

        // Credit 5, buy B: one change pulse follows
        coin_in(2'b10);
        coin_in(2'b10);
        coin_in(2'b01);
        cyc(2'b00, 2'b10, 1'b0);
        check("disp_b_pulse", vm.dispense_b, 1);
        cyc(2'b00, 2'b00, 1'b0);
        check("b_change", vm.change, 1);
        check("b_credit_left", vm.credit, 1);
        idle(2);

        // Credit 2, cancel: two change pulses
        coin_in(2'b10);
        cyc(2'b11, 2'b00, 1'b0);
        check("cancel_busy", vm.busy, 1);
        idle(4);

        // Saturation at 14, then reject during change
        repeat (7) coin_in(2'b10);
        cyc(2'b10, 2'b00, 1'b0);
        check("sat_reject", vm.reject, 1);
        check("sat_credit", vm.credit, 14);
        cyc(2'b00, 2'b00, 1'b0);
        cyc(2'b11, 2'b00, 1'b0);
        cyc(2'b00, 2'b00, 1'b0);
        cyc(2'b01, 2'b00, 1'b0);
        check("busy_reject", vm.reject, 1);
        check("busy_reject_credit", vm.credit, 12);
        idle(14);

        // Drain the remaining seven A units, then refill
        repeat (7) begin
            coin_in(2'b10);
            coin_in(2'b01);
            cyc(2'b00, 2'b01, 1'b0);
            cyc(2'b00, 2'b00, 1'b0);
        end
        check("empty_a_set", vm.empty_a, 1);
        coin_in(2'b10);
        coin_in(2'b01);
        cyc(2'b00, 2'b01, 1'b0);
        check("empty_sel_ignored", vm.busy, 0);
        check("empty_sel_credit", vm.credit, 3);
        cyc(2'b11, 2'b00, 1'b0);
        idle(5);
        cyc(2'b00, 2'b00, 1'b1);
        check("refill_empty_a", vm.empty_a, 0);
        idle(2);

        // Idle credit: held without the timeout, refunded with it
        coin_in(2'b10);
        coin_in(2'b01);
        idle(80);
`ifdef CYQ_VM_TIMEOUT_EN
        check("timeout_credit", vm.credit, 0);
`else
        check("hold_credit", vm.credit, 3);
`endif
        cyc(2'b11, 2'b00, 1'b0);
        idle(5);

        // Reset in the middle of a change burst
        coin_in(2'b10);
        coin_in(2'b10);
        coin_in(2'b01);
        cyc(2'b11, 2'b00, 1'b0);
        cyc(2'b00, 2'b00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_change", vm.change, 0);
        check("midrst_busy", vm.busy, 0);
        check("midrst_credit", vm.credit, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rr = $urandom_range(0, 19);
            rc = (rr < 10) ? 2'b00 : (rr < 14) ? 2'b01 : (rr < 18) ? 2'b10 : 2'b11;
            rr = $urandom_range(0, 9);
            rs = (rr < 6) ? 2'b00 : (rr < 8) ? 2'b01 : (rr < 9) ? 2'b10 : 2'b11;
            cyc(rc, rs, ($urandom_range(0, 39) == 0));
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
